// File: rtl/usbsd_pio_pkg.sv
// usbsd_pio_pkg: register map and edge-capture mode encodings shared by the PIO controller
package usbsd_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_INPUT    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_PULSE    = 3'd6;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/usbsd_pio_ctl_if.sv
// usbsd_pio_ctl_if: word-addressed register bus with zero-wait-state reads
interface usbsd_pio_ctl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/usbsd_pio_edge.sv
// usbsd_pio_edge: two-flop input synchroniser plus previous-value flop and edge detector
module usbsd_pio_edge import usbsd_pio_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int EDGE_TYPE  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] sync,
  output logic [DATA_WIDTH-1:0] edges
);
  logic [DATA_WIDTH-1:0] s1, prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1   <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      s1   <= in_port;
      sync <= s1;
      prev <= sync;
    end
  assign edges = EDGE_TYPE == EDGE_FALL ? ~sync & prev :
                 EDGE_TYPE == EDGE_ANY  ? sync ^ prev  : sync & ~prev;
endmodule

// File: rtl/usbsd_pio_ctl.sv
// usbsd_pio_ctl: PIO register file with set/clear, sticky edge capture, irq mask and one-shot pulse timer
module usbsd_pio_ctl import usbsd_pio_pkg::*; #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    EDGE_TYPE   = 0,
  parameter int                    PULSE_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  usbsd_pio_ctl_if.slave        bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);
  logic [DATA_WIDTH-1:0] data, irq_mask, edge_cap, pulse_bits, sync, edges, wd;
  logic [DATA_WIDTH-1:0] data_nx, pulse_nx, edge_nx;
  logic [15:0] cnt;
  logic wr, pulse_wr, expire, unused_wd;
  usbsd_pio_edge #(.DATA_WIDTH(DATA_WIDTH), .EDGE_TYPE(EDGE_TYPE)) u_edge (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .sync(sync), .edges(edges)
  );
  assign wd        = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  assign wr        = bus.chipselect & ~bus.write_n;
  assign pulse_wr  = wr && bus.address == ADDR_PULSE && |wd;
  // a retrigger landing on the last pulse cycle extends the pulse instead of ending it
  assign expire    = cnt == 16'd1 && !pulse_wr;
  always_comb begin
    data_nx  = expire ? data & ~pulse_bits : data;
    pulse_nx = expire ? '0 : pulse_bits;
    if (wr && bus.address == ADDR_DATA) begin
      data_nx  = wd;
      pulse_nx = pulse_nx & wd;
    end
    if (wr && bus.address == ADDR_OUTSET) data_nx = data_nx | wd;
    if (wr && bus.address == ADDR_OUTCLR) begin
      data_nx  = data_nx & ~wd;
      pulse_nx = pulse_nx & ~wd;
    end
    if (pulse_wr) begin
      data_nx  = data_nx | wd;
      pulse_nx = pulse_nx | wd;
    end
    edge_nx = (edge_cap & ~(wr && bus.address == ADDR_EDGE_CAP ? wd : '0)) | edges;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data       <= RESET_VALUE;
      irq_mask   <= '0;
      edge_cap   <= '0;
      pulse_bits <= '0;
      cnt        <= '0;
    end else begin
      data       <= data_nx;
      pulse_bits <= pulse_nx;
      edge_cap   <= edge_nx;
      if (wr && bus.address == ADDR_IRQ_MASK) irq_mask <= wd;
      cnt <= pulse_wr ? 16'(PULSE_LEN) : cnt != 16'd0 ? cnt - 16'd1 : cnt;
    end
  assign bus.readdata = bus.address == ADDR_DATA     ? 32'(data)       :
                        bus.address == ADDR_INPUT    ? 32'(sync)       :
                        bus.address == ADDR_IRQ_MASK ? 32'(irq_mask)   :
                        bus.address == ADDR_EDGE_CAP ? 32'(edge_cap)   :
                        bus.address == ADDR_PULSE    ? 32'(pulse_bits) : 32'd0;
  assign out_port = data;
  assign irq      = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_usbsd_pio_ctl.sv
// tb_usbsd_pio_ctl: directed and randomized checks against a cycle-level behavioural model
module tb_usbsd_pio_ctl;
  import usbsd_pio_pkg::*;
  localparam int DW = 16;
  localparam logic [15:0] RV = 16'h0042;
  localparam int PL = 16;
  logic clk = 0, reset_n = 0;
  logic [DW-1:0] in_port, out_port;
  logic irq;
  usbsd_pio_ctl_if bus();
  usbsd_pio_ctl #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .EDGE_TYPE(EDGE_RISE), .PULSE_LEN(PL)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .in_port(in_port), .out_port(out_port), .irq(irq)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [15:0] m_data, m_mask, m_ec, m_pb;
  int m_rem, n, h;
  logic [15:0] samp [8192];
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] sync_now();
    return n >= 2 ? samp[n-2] : 16'h0;
  endfunction
  function automatic logic [31:0] exp_rd(logic [2:0] a);
    case (a)
      3'd0: return {16'h0, m_data};
      3'd1: return {16'h0, sync_now()};
      3'd2: return {16'h0, m_mask};
      3'd3: return {16'h0, m_ec};
      3'd6: return {16'h0, m_pb};
      default: return 32'h0;
    endcase
  endfunction
  task automatic model_reset();
    m_data = RV; m_mask = '0; m_ec = '0; m_pb = '0; m_rem = 0; n = 0;
  endtask
  // samp[k] is in_port as seen on the k-th edge since reset; INPUT shows it two edges later
  task automatic model_step();
    logic [15:0] s2, prev, wd, nd, npb;
    logic wr, pw;
    logic [2:0] a;
    s2 = sync_now();
    prev = n >= 3 ? samp[n-3] : 16'h0;
    a = bus.address;
    wd = bus.writedata[15:0];
    wr = bus.chipselect && !bus.write_n;
    pw = wr && a == 3'd6 && wd != 0;
    nd = m_data;
    npb = m_pb;
    if (m_rem == 1 && !pw) begin nd &= ~m_pb; npb = '0; end
    if (wr)
      case (a)
        3'd0: begin nd = wd; npb &= wd; end
        3'd2: m_mask = wd;
        3'd4: nd |= wd;
        3'd5: begin nd &= ~wd; npb &= ~wd; end
        3'd6: if (pw) begin nd |= wd; npb |= wd; end
        default: ;
      endcase
    m_ec = (m_ec & ~((wr && a == 3'd3) ? wd : 16'h0)) | (s2 & ~prev);
    m_data = nd;
    m_pb = npb;
    m_rem = pw ? PL : (m_rem > 0 ? m_rem - 1 : 0);
    samp[n] = in_port;
    n++;
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    chk("out_port", 32'(out_port), 32'(m_data));
    chk("irq", 32'(irq), 32'(|(m_ec & m_mask)));
    chk("readdata", bus.readdata, exp_rd(bus.address));
  endtask
  task automatic wr(logic [2:0] a, logic [31:0] d);
    bus.chipselect = 1; bus.write_n = 0; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 0; bus.write_n = 1;
  endtask
  task automatic rd(string tag, logic [2:0] a, logic [31:0] e);
    bus.address = a;
    #1 chk(tag, bus.readdata, e);
  endtask
  initial begin
    bus.chipselect = 0; bus.write_n = 1; bus.address = 0; bus.writedata = 0; in_port = 0;
    model_reset();
    tick(); tick();
    chk("rst_out", 32'(out_port), 32'(RV));
    chk("rst_irq", 32'(irq), 0);
    rd("rst_rd_data", 3'd0, 32'(RV));
    rd("rst_rd_edge", 3'd3, 0);
    reset_n = 1;
    wr(3'd0, 32'h0000A5A5); wr(3'd4, 32'h0000000F); wr(3'd5, 32'h00000005);
    chk("setclr_out", 32'(out_port), 32'h0000A5AA);
    rd("setclr_rd", 3'd0, 32'h0000A5AA);
    rd("rd_outset_zero", 3'd4, 0);
    wr(3'd2, 32'h1);
    in_port = 16'h0001;
    tick(); tick();
    chk("edge_early", 32'(irq), 0);
    tick();
    chk("edge_irq", 32'(irq), 1);
    rd("edge_cap", 3'd3, 32'h1);
    wr(3'd3, 32'h1);
    chk("edge_clr_irq", 32'(irq), 0);
    in_port = 16'h0;
    repeat (4) tick();
    rd("no_fall_cap", 3'd3, 0);
    in_port = 16'h0001;
    tick(); tick();
    wr(3'd3, 32'h1);
    rd("w1c_vs_edge", 3'd3, 32'h1);
    wr(3'd3, 32'h1);
    rd("w1c_clear", 3'd3, 0);
    wr(3'd0, 0);
    wr(3'd6, 32'h100);
    h = 0;
    for (int g = 0; g < 100 && out_port[8]; g++) begin h++; tick(); end
    chk("pulse_len", 32'(h), 32'(PL));
    wr(3'd6, 32'h100);
    h = 0;
    repeat (9) begin h += int'(out_port[8]); tick(); end
    h += int'(out_port[8]);
    wr(3'd6, 32'h100);
    for (int g = 0; g < 100 && out_port[8]; g++) begin h++; tick(); end
    chk("retrig_len", 32'(h), 32'd26);
    wr(3'd6, 32'h100);
    repeat (PL - 1) tick();
    wr(3'd0, 32'h100);
    chk("expiry_data_wins", 32'(out_port[8]), 1);
    rd("expiry_pulse_bits", 3'd6, 0);
    wr(3'd0, 0); in_port = 0;
    wr(3'd6, 32'h0300);
    repeat (3) tick();
    #2 reset_n = 0;
    #1 chk("async_rst_out", 32'(out_port), 32'(RV));
    model_reset();
    tick(); tick();
    reset_n = 1;
    repeat (PL + 4) tick();
    chk("no_residual", 32'(out_port), 32'(RV));
    rd("no_residual_pb", 3'd6, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) in_port ^= 16'($urandom) & 16'($urandom);
      bus.chipselect = 1'($urandom_range(1));
      bus.write_n = $urandom_range(2) == 0;
      bus.address = 3'($urandom_range(7));
      bus.writedata = $urandom;
      if ($urandom_range(4) == 0) bus.writedata[15:0] = 16'h0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
